// File: rtl/obi_mem_arbiter.sv
// Two-port OBI arbiter in front of a single-port synchronous RAM, with read-modify-write for partial stores.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port wins conflicts.
module obi_mem_arbiter #(
  parameter int unsigned MEM_AW = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RMW  = 1'b1;

  // Keeps address bits [MEM_AW-1:2]; everything above and the byte offset read as zero.
  localparam logic [31:0] ADDR_MASK =
    ((MEM_AW >= 32) ? 32'hFFFF_FFFF : ((32'h1 << MEM_AW) - 32'h1)) & 32'hFFFF_FFFC;

  logic [0:0]  state_reg;
  logic        instr_rvalid_reg;
  logic        data_rvalid_reg;
  logic        data_rd_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] rmw_addr_reg;
  logic [31:0] rmw_wdata_reg;
  logic [3:0]  rmw_be_reg;

  logic        idle;
  logic        pick_data;
  logic        grant_instr;
  logic        grant_data;
  logic        data_full_wr;
  logic        data_part_wr;
  logic [31:0] merge_data;

`ifdef OBI_ARB_ROUND_ROBIN_EN
  logic last_instr_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_instr_reg <= 1'b1;
    end else if (grant_instr) begin
      last_instr_reg <= 1'b1;
    end else if (grant_data) begin
      last_instr_reg <= 1'b0;
    end
  end

  assign pick_data = last_instr_reg;
`else
  assign pick_data = 1'b1;
`endif

  // Grants are gated by reset so nothing is handed out while rst_ni is low.
  always_comb begin
    idle         = rst_ni && (state_reg == ST_IDLE);
    grant_data   = idle && data_req_i && (!instr_req_i || pick_data);
    grant_instr  = idle && instr_req_i && !grant_data;
    data_full_wr = grant_data && data_we_i && (data_be_i == 4'hF);
    data_part_wr = grant_data && data_we_i && (data_be_i != 4'hF);
  end

  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merge_data[8*gi +: 8] = rmw_be_reg[gi] ? rmw_wdata_reg[8*gi +: 8]
                                                    : mem_rdata_i[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    mem_we_o    = (state_reg == ST_RMW) || data_full_wr;
    mem_addr_o  = mem_addr_reg;
    mem_wdata_o = mem_wdata_reg;
    if (state_reg == ST_RMW) begin
      mem_addr_o  = rmw_addr_reg;
      mem_wdata_o = merge_data;
    end else if (grant_data) begin
      mem_addr_o = data_addr_i & ADDR_MASK;
      if (data_full_wr) begin
        mem_wdata_o = data_wdata_i;
      end
    end else if (grant_instr) begin
      mem_addr_o = instr_addr_i & ADDR_MASK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= ST_IDLE;
      instr_rvalid_reg <= 1'b0;
      data_rvalid_reg  <= 1'b0;
      data_rd_reg      <= 1'b0;
      mem_addr_reg     <= 32'h0;
      mem_wdata_reg    <= 32'h0;
      rmw_addr_reg     <= 32'h0;
      rmw_wdata_reg    <= 32'h0;
      rmw_be_reg       <= 4'h0;
    end else begin
      state_reg        <= data_part_wr ? ST_RMW : ST_IDLE;
      instr_rvalid_reg <= grant_instr;
      // A partial write answers only after its RMW cycle, not after its grant.
      data_rvalid_reg  <= (grant_data && !data_part_wr) || (state_reg == ST_RMW);
      data_rd_reg      <= grant_data && !data_we_i;
      mem_addr_reg     <= mem_addr_o;
      mem_wdata_reg    <= mem_wdata_o;
      if (data_part_wr) begin
        rmw_addr_reg  <= data_addr_i & ADDR_MASK;
        rmw_wdata_reg <= data_wdata_i;
        rmw_be_reg    <= data_be_i;
      end
    end
  end

  assign instr_rvalid_o = instr_rvalid_reg;
  assign data_rvalid_o  = data_rvalid_reg;
  assign instr_rdata_o  = instr_rvalid_reg ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_reg && data_rd_reg) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: a synchronous RAM model plus per-port expected-response queues.
module tb_obi_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i;

  obi_mem_arbiter #(.MEM_AW(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_addr_i   (instr_addr_i),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_we_o       (mem_we_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: read data appears the cycle after the address; backdoor port for preloading.
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = 32'h0;
  logic [31:0] bd_data = 32'h0;

  always @(posedge clk_i) begin
    if (bd_we) mem[bd_addr[15:2]] <= bd_data;
    else if (mem_we_o) mem[mem_addr_o[15:2]] <= mem_wdata_o;
    mem_rdata_i <= mem[mem_addr_o[15:2]];
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];
  logic [31:0] exp_w;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] value);
    bd_we = 1'b1; bd_addr = addr; bd_data = value;
    ref_mem[addr[15:2]] = value;
    next_cycle();
    bd_we = 1'b0;
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h100; data_addr_i = 32'h200;
    @(negedge clk_i); @(negedge clk_i);
    n_vec++; if (instr_gnt_o !== 1'b0) begin n_err++; $display("FAIL reset_instr_gnt: got %b want 0", instr_gnt_o); end
    n_vec++; if (data_gnt_o !== 1'b0) begin n_err++; $display("FAIL reset_data_gnt: got %b want 0", data_gnt_o); end
    n_vec++; if ({instr_rvalid_o, data_rvalid_o, mem_we_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {instr_rvalid_o, data_rvalid_o, mem_we_o}); end
    n_vec++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    n_vec++; if (mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata_o); end
    n_vec++; if ({instr_rdata_o, data_rdata_o} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", instr_rdata_o, data_rdata_o); end
    idle_inputs();
    rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_read();
    preload(32'h100, 32'hDEADBEEF);
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    q_i.push_back(ref_mem[32'h100 >> 2]);
    @(negedge clk_i);
    n_vec++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin
      n_err++; $display("FAIL single_gnt: got i%b d%b want i1 d0", instr_gnt_o, data_gnt_o); end
    n_vec++; if (mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin
      n_err++; $display("FAIL single_mem: got addr %h we %b want 100 0", mem_addr_o, mem_we_o); end
    next_cycle();
    instr_req_i = 1'b0;
    @(negedge clk_i);
    exp_w = q_i.pop_front();
    n_vec++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== exp_w) begin
      n_err++; $display("FAIL single_rsp: got rvalid %b rdata %h want 1 %h", instr_rvalid_o, instr_rdata_o, exp_w); end
    next_cycle();
    @(negedge clk_i);
    n_vec++; if (instr_rvalid_o !== 1'b0) begin n_err++; $display("FAIL single_rvalid_len: got %b want 0", instr_rvalid_o); end
    next_cycle();
  endtask

  task automatic test_addr_mask();
    preload(32'h104, 32'h5A5A0104);
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'hFFFF0104;
    q_d.push_back(ref_mem[32'h104 >> 2]);
    @(negedge clk_i);
    n_vec++; if (data_gnt_o !== 1'b1 || mem_addr_o !== 32'h00000104) begin
      n_err++; $display("FAIL addr_mask: got gnt %b addr %h want 1 00000104", data_gnt_o, mem_addr_o); end
    next_cycle();
    data_req_i = 1'b0;
    @(negedge clk_i);
    exp_w = q_d.pop_front();
    n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp_w) begin
      n_err++; $display("FAIL addr_mask_rsp: got rvalid %b rdata %h want 1 %h", data_rvalid_o, data_rdata_o, exp_w); end
    next_cycle();
  endtask

  task automatic test_arbitration();
    logic want_d, want_i, prev_d, prev_i;
    int cnt_d, cnt_i, exp_cnt_d;
    rst_ni = 1'b0; next_cycle(); rst_ni = 1'b1; next_cycle();
    for (int k = 0; k < 4; k++) begin
      preload(32'h400 + 32'(4 * k), 32'hA0000000 + 32'(k));
      preload(32'h500 + 32'(4 * k), 32'hB0000000 + 32'(k));
    end
    prev_d = 1'b0; prev_i = 1'b0; cnt_d = 0; cnt_i = 0;
    for (int k = 0; k < 5; k++) begin
      instr_req_i = (k < 4); data_req_i = (k < 4); data_we_i = 1'b0;
      instr_addr_i = 32'h400 + 32'(4 * k); data_addr_i = 32'h500 + 32'(4 * k);
      if (k < 4) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
        want_d = (k % 2 == 0);
`else
        want_d = 1'b1;
`endif
      end else begin
        want_d = 1'b0;
      end
      want_i = (k < 4) && !want_d;
      if (want_d) q_d.push_back(ref_mem[data_addr_i[15:2]]);
      if (want_i) q_i.push_back(ref_mem[instr_addr_i[15:2]]);
      @(negedge clk_i);
      cnt_d += int'(data_gnt_o); cnt_i += int'(instr_gnt_o);
      n_vec++; if ({data_gnt_o, instr_gnt_o} !== {want_d, want_i}) begin
        n_err++; $display("FAIL arb_gnt[%0d]: got d%b i%b want d%b i%b", k, data_gnt_o, instr_gnt_o, want_d, want_i); end
      n_vec++; if ({data_rvalid_o, instr_rvalid_o} !== {prev_d, prev_i}) begin
        n_err++; $display("FAIL arb_rvalid[%0d]: got d%b i%b want d%b i%b", k, data_rvalid_o, instr_rvalid_o, prev_d, prev_i); end
      if (prev_d && q_d.size() > 0) begin
        exp_w = q_d.pop_front();
        n_vec++; if (data_rdata_o !== exp_w) begin
          n_err++; $display("FAIL arb_drdata[%0d]: got %h want %h", k, data_rdata_o, exp_w); end
      end
      if (prev_i && q_i.size() > 0) begin
        exp_w = q_i.pop_front();
        n_vec++; if (instr_rdata_o !== exp_w) begin
          n_err++; $display("FAIL arb_irdata[%0d]: got %h want %h", k, instr_rdata_o, exp_w); end
      end
      prev_d = want_d; prev_i = want_i;
      next_cycle();
    end
    idle_inputs();
`ifdef OBI_ARB_ROUND_ROBIN_EN
    exp_cnt_d = 2;
`else
    exp_cnt_d = 4;
`endif
    n_vec++; if (cnt_d != exp_cnt_d || cnt_i != 4 - exp_cnt_d) begin
      n_err++; $display("FAIL arb_counts: got d%0d i%0d want d%0d i%0d", cnt_d, cnt_i, exp_cnt_d, 4 - exp_cnt_d); end
    q_d.delete(); q_i.delete();
  endtask

  task automatic test_partial_write();
    preload(32'h200, 32'h11223344);
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0010;
    data_addr_i = 32'h200; data_wdata_i = 32'h0000AA00;
    exp_w = merge_bytes(ref_mem[32'h200 >> 2], 32'h0000AA00, 4'b0010);
    ref_mem[32'h200 >> 2] = exp_w;
    q_d.push_back(32'h0);
    @(negedge clk_i);
    n_vec++; if (data_gnt_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h200) begin
      n_err++; $display("FAIL pw_c0: got gnt %b we %b addr %h want 1 0 200", data_gnt_o, mem_we_o, mem_addr_o); end
    next_cycle();
    // Master changes everything after the grant; the RMW must use the captured values.
    data_req_i = 1'b0; data_wdata_i = 32'hFFFFFFFF; data_be_i = 4'hF; data_addr_i = 32'h300;
    instr_req_i = 1'b1; instr_addr_i = 32'h200;
    @(negedge clk_i);
    n_vec++; if (mem_we_o !== 1'b1 || mem_wdata_o !== exp_w || mem_addr_o !== 32'h200) begin
      n_err++; $display("FAIL pw_c1_mem: got we %b wdata %h addr %h want 1 %h 200", mem_we_o, mem_wdata_o, mem_addr_o, exp_w); end
    n_vec++; if ({instr_gnt_o, data_gnt_o, data_rvalid_o} !== 3'b000) begin
      n_err++; $display("FAIL pw_c1_hs: got i%b d%b rv%b want 000", instr_gnt_o, data_gnt_o, data_rvalid_o); end
    next_cycle();
    q_i.push_back(ref_mem[32'h200 >> 2]);
    @(negedge clk_i);
    exp_w = q_d.pop_front();
    n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp_w) begin
      n_err++; $display("FAIL pw_c2_rsp: got rvalid %b rdata %h want 1 %h", data_rvalid_o, data_rdata_o, exp_w); end
    n_vec++; if (instr_gnt_o !== 1'b1 || mem_we_o !== 1'b0) begin
      n_err++; $display("FAIL pw_c2_igrant: got gnt %b we %b want 1 0", instr_gnt_o, mem_we_o); end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    exp_w = q_i.pop_front();
    n_vec++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== exp_w) begin
      n_err++; $display("FAIL pw_readback: got rvalid %b rdata %h want 1 %h", instr_rvalid_o, instr_rdata_o, exp_w); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
    data_addr_i = 32'h300; data_wdata_i = 32'hCAFEF00D;
    ref_mem[32'h300 >> 2] = 32'hCAFEF00D;
    q_d.push_back(32'h0);
    @(negedge clk_i);
    n_vec++; if (data_gnt_o !== 1'b1 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL b2b_wr: got gnt %b we %b wdata %h want 1 1 cafef00d", data_gnt_o, mem_we_o, mem_wdata_o); end
    next_cycle();
    data_we_i = 1'b0; data_wdata_i = 32'h0;
    q_d.push_back(ref_mem[32'h300 >> 2]);
    @(negedge clk_i);
    n_vec++; if (data_gnt_o !== 1'b1 || mem_we_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_rd_gnt: got gnt %b we %b want 1 0", data_gnt_o, mem_we_o); end
    exp_w = q_d.pop_front();
    n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp_w) begin
      n_err++; $display("FAIL b2b_wr_rsp: got rvalid %b rdata %h want 1 %h", data_rvalid_o, data_rdata_o, exp_w); end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    exp_w = q_d.pop_front();
    n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp_w) begin
      n_err++; $display("FAIL b2b_rd_rsp: got rvalid %b rdata %h want 1 %h", data_rvalid_o, data_rdata_o, exp_w); end
    n_vec++; if (mem_we_o !== 1'b0 || mem_addr_o !== 32'h300) begin
      n_err++; $display("FAIL idle_hold: got we %b addr %h want 0 300", mem_we_o, mem_addr_o); end
    next_cycle();
  endtask

  task automatic test_reset_rmw();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0001;
    data_addr_i = 32'h200; data_wdata_i = 32'h000000EE;
    @(negedge clk_i);
    n_vec++; if (data_gnt_o !== 1'b1) begin n_err++; $display("FAIL rrmw_gnt: got %b want 1", data_gnt_o); end
    next_cycle();
    idle_inputs();
    #1;
    n_vec++; if (mem_we_o !== 1'b1) begin n_err++; $display("FAIL rrmw_in_rmw: got we %b want 1", mem_we_o); end
    rst_ni = 1'b0;
    #1;
    n_vec++; if (mem_we_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL rrmw_async: got we %b addr %h want 0 0", mem_we_o, mem_addr_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk_i);
      n_vec++; if ({data_rvalid_o, instr_rvalid_o, mem_we_o} !== 3'b000) begin
        n_err++; $display("FAIL rrmw_after[%0d]: got rv%b%b we%b want 000", k, data_rvalid_o, instr_rvalid_o, mem_we_o); end
    end
    next_cycle();
    instr_req_i = 1'b1; instr_addr_i = 32'h200;
    q_i.push_back(ref_mem[32'h200 >> 2]);
    next_cycle();
    instr_req_i = 1'b0;
    @(negedge clk_i);
    exp_w = q_i.pop_front();
    n_vec++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== exp_w) begin
      n_err++; $display("FAIL rrmw_word: got rvalid %b rdata %h want 1 %h", instr_rvalid_o, instr_rdata_o, exp_w); end
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_single_read();
    test_addr_mask();
    test_arbitration();
    test_partial_write();
    test_back_to_back();
    test_reset_rmw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 Parameter MEM_AW, default 16: number of low byte-address bits forwarded to memory; upper mem_addr_o bits SHALL be 0.
REQ-002 clk_i  in  1  core clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1 each  instruction port handshake.
REQ-005 instr_addr_i  in  32  instruction byte address; instr_rdata_o  out  32  read data.
REQ-006 data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1 each  data port handshake.
REQ-007 data_we_i  in  1  write enable; data_be_i  in  4  byte enables; data_addr_i, data_wdata_i  in  32; data_rdata_o  out  32.
REQ-008 mem_addr_o  out  32  word-aligned byte address {addr[MEM_AW-1:2],2'b00}, zero-extended.
REQ-009 mem_wdata_o  out  32; mem_we_o  out  1; mem_rdata_i  in  32, valid the cycle after the address is presented.

Function
REQ-010 Transfer SHALL occur when req and gnt are both high in the same cycle; gnt SHALL be combinational from req and state, at most one port granted per cycle.
REQ-011 States: IDLE, RMW; reset state IDLE.
REQ-012 IDLE: a granted read or full-word write (be==4'hF) SHALL drive memory in the grant cycle; the next grant MAY occur in the following cycle, for one access per cycle.
REQ-013 rvalid SHALL assert on the granting port exactly one cycle after gnt, for one cycle; for a read, rdata SHALL equal mem_rdata_i.
REQ-014 Write responses SHALL assert rvalid with data_rdata_o = 32'h0.
REQ-015 Partial write (we=1, be!=4'hF): the grant cycle SHALL issue a memory read of the word (mem_we_o=0) and enter RMW.
REQ-016 RMW (one cycle): mem_we_o=1; mem_wdata_o = per byte, data_wdata byte if be bit set, else mem_rdata_i byte; no gnt on either port; return to IDLE.
REQ-017 Partial write rvalid SHALL assert in the cycle after the RMW cycle.
REQ-018 Write data, byte enables and address of a partial write SHALL be registered at grant; master changes after grant SHALL have no effect.
REQ-019 Arbitration on simultaneous req in IDLE: per Configuration; a single requester SHALL always be granted in IDLE.
REQ-020 A req held across the RMW cycle SHALL be granted in the first IDLE cycle, subject to arbitration.
REQ-021 No requests: mem_we_o=0, mem_addr_o and mem_wdata_o hold their last values.

Reset
REQ-022 Asserting rst_ni low SHALL force IDLE, clear pending rvalid and RMW state and reset the round-robin pointer to "instr last"; this SHALL apply mid-transaction.
REQ-023 Reset values: instr_gnt_o=0 and data_gnt_o=0 while in reset; instr_rvalid_o=0, data_rvalid_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, instr_rdata_o=0, data_rdata_o=0.
REQ-024 A transaction interrupted by reset SHALL produce no rvalid and no memory write after reset release.

Configuration
REQ-025 Macro OBI_ARB_ROUND_ROBIN_EN defined: on conflict, the port not granted most recently SHALL win; the pointer SHALL update on every grant.
REQ-026 Macro undefined: on conflict the data port SHALL always win; no pointer register SHALL exist.

Verification
REQ-027 Mem word 0x100=32'hDEADBEEF; instr read 0x100 alone -> gnt cycle 0, instr_rvalid cycle 1, rdata 32'hDEADBEEF.
REQ-028 Both ports read every cycle for 4 cycles -> without macro: data granted 4 times, instr 0; with macro: grants alternate D,I,D,I (pointer starts "instr last").
REQ-029 Word 0x200=32'h11223344; data write be=4'b0010, wdata=32'h0000AA00 -> cycle 0 read, cycle 1 mem_we_o=1 with wdata 32'h1122AA44, cycle 2 data_rvalid; instr req held during cycle 1 gets no gnt, is granted in cycle 2.
REQ-030 Full-word write 0x300=32'hCAFEF00D, then read 0x300 next cycle -> read rvalid returns 32'hCAFEF00D, one access per cycle, no stall.
REQ-031 rst_ni low during RMW cycle -> mem_we_o=0 immediately, no rvalid after release, word 0x200 unchanged.
REQ-032 Address 32'hFFFF0104 with MEM_AW=16 -> mem_addr_o=32'h00000104.
